// File: rtl/decodificador_gray_binario.sv
// Gray-to-binary decoder with an input synchronizer and single-step tracking.
// Reports step direction, per-step pulses and multi-bit jumps, with a saturating error count.
module decodificador_gray_binario #(
  parameter int ANCHO       = 4,
  parameter int ETAPAS_SYNC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] gray_in,
  input  logic             en,
  output logic [ANCHO-1:0] binario,
  output logic             valido,
  output logic             paso,
  output logic             dir,
  output logic             error,
  output logic [7:0]       cnt_error
);

  localparam int FW = $clog2(ETAPAS_SYNC) + 1;
  localparam logic [ANCHO-1:0] UNO = {{(ANCHO-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {LLENADO, INICIO, TRACK, FALLO} estado_t;

  function automatic logic [ANCHO-1:0] gray_a_bin(input logic [ANCHO-1:0] g);
    logic [ANCHO-1:0] b;
    b[ANCHO-1] = g[ANCHO-1];
    for (int i = ANCHO-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when exactly one bit of x is set.
  function automatic logic un_bit(input logic [ANCHO-1:0] x);
    return (x != '0) && ((x & (x - UNO)) == '0);
  endfunction

  logic [ANCHO-1:0] sync_q [ETAPAS_SYNC];
  logic [ANCHO-1:0] g_s, b, dif;

  estado_t          estado_q, estado_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [ANCHO-1:0] g_prev_q, g_prev_d;
  logic [ANCHO-1:0] binario_q, binario_d;
  logic             valido_q, valido_d;
  logic             paso_q, paso_d;
  logic             dir_q, dir_d;
  logic             error_q, error_d;
  logic [7:0]       cnt_error_q, cnt_error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ETAPAS_SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < ETAPAS_SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s = sync_q[ETAPAS_SYNC-1];
  assign b   = gray_a_bin(g_s);
  assign dif = g_s ^ g_prev_q;

  always_comb begin
    estado_d    = estado_q;
    fill_d      = fill_q;
    g_prev_d    = g_prev_q;
    binario_d   = binario_q;
    valido_d    = valido_q;
    dir_d       = dir_q;
    cnt_error_d = cnt_error_q;
    paso_d      = 1'b0;
    error_d     = 1'b0;
    unique case (estado_q)
      LLENADO: begin
        // Hold off until the synchronizer carries a real sample instead of reset zeros.
        if (fill_q == FW'(ETAPAS_SYNC-1)) estado_d = INICIO;
        else                              fill_d   = fill_q + FW'(1);
      end
      INICIO: if (en) begin
        binario_d = b;
        g_prev_d  = g_s;
        valido_d  = 1'b1;
        estado_d  = TRACK;
      end
      TRACK: if (en) begin
        if (un_bit(dif)) begin
          binario_d = b;
          g_prev_d  = g_s;
          paso_d    = 1'b1;
          dir_d     = (b == binario_q + UNO);
        end else if (dif != '0) begin
          error_d   = 1'b1;
          valido_d  = 1'b0;
          g_prev_d  = g_s;
          estado_d  = FALLO;
          if (cnt_error_q != 8'hFF) cnt_error_d = cnt_error_q + 8'd1;
        end
      end
      FALLO: if (en) begin
        // Two identical consecutive samples are needed before trusting the input again.
        if (dif == '0) begin
          binario_d = b;
          valido_d  = 1'b1;
          estado_d  = TRACK;
        end else begin
          g_prev_d  = g_s;
        end
      end
      default: estado_d = LLENADO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= LLENADO;
      fill_q      <= '0;
      g_prev_q    <= '0;
      binario_q   <= '0;
      valido_q    <= 1'b0;
      paso_q      <= 1'b0;
      dir_q       <= 1'b0;
      error_q     <= 1'b0;
      cnt_error_q <= '0;
    end else begin
      estado_q    <= estado_d;
      fill_q      <= fill_d;
      g_prev_q    <= g_prev_d;
      binario_q   <= binario_d;
      valido_q    <= valido_d;
      paso_q      <= paso_d;
      dir_q       <= dir_d;
      error_q     <= error_d;
      cnt_error_q <= cnt_error_d;
    end
  end

  assign binario   = binario_q;
  assign valido    = valido_q;
  assign paso      = paso_q;
  assign dir       = dir_q;
  assign error     = error_q;
  assign cnt_error = cnt_error_q;

endmodule

// File: tb/tb_decodificador_gray_binario.sv
// Scoreboard bench for decodificador_gray_binario: expected step/error events are queued
// by the stimulus and consumed by a monitor whenever paso or error pulses.
module tb_decodificador_gray_binario;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] gray_in = 4'b0000;
  logic       en = 1'b0;
  logic [3:0] binario;
  logic       valido, paso, dir, error;
  logic [7:0] cnt_error;

  decodificador_gray_binario #(.ANCHO(4), .ETAPAS_SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .en(en),
    .binario(binario), .valido(valido), .paso(paso), .dir(dir),
    .error(error), .cnt_error(cnt_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       es_err;
    logic [3:0] bin;
    logic       dir;
    logic       val;
    logic [7:0] cnt;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  pasos = 0;
  int  cnt_exp = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (paso || error)) begin
      if (paso) pasos++;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event paso=%0d error=%0d binario=%0d t=%0t",
                 paso, error, binario, $time);
      end else begin
        e = q.pop_front();
        chk("ev_error", int'(error), int'(e.es_err));
        chk("ev_paso", int'(paso), int'(!e.es_err));
        chk("ev_binario", int'(binario), int'(e.bin));
        chk("ev_dir", int'(dir), int'(e.dir));
        chk("ev_valido", int'(valido), int'(e.val));
        chk("ev_cnt_error", int'(cnt_error), int'(e.cnt));
      end
    end
  end

  // Drive a new Gray word and wait until it has been decoded (2 sync edges + 1 sample edge).
  task automatic apply(input logic [3:0] g);
    gray_in = g;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_step(input logic [3:0] g, input logic [3:0] b, input logic d);
    q.push_back('{es_err: 1'b0, bin: b, dir: d, val: 1'b1, cnt: 8'(cnt_exp)});
    apply(g);
  endtask

  task automatic apply_fault(input logic [3:0] g, input logic [3:0] held, input logic d);
    if (cnt_exp < 255) cnt_exp++;
    q.push_back('{es_err: 1'b1, bin: held, dir: d, val: 1'b0, cnt: 8'(cnt_exp)});
    apply(g);
  endtask

  task automatic step_bin(input int b, input logic d);
    logic [3:0] bb;
    bb = 4'(b);
    apply_step(bb ^ (bb >> 1), bb, d);
  endtask

  initial begin
    int p0;
    // Reset with live inputs
    gray_in = 4'b1010; en = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_binario", int'(binario), 0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_paso", int'(paso), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_cnt_error", int'(cnt_error), 0);
    rst_n = 1'b1;
    @(posedge clk); #1; chk("fill_edge1_valido", int'(valido), 0);
    @(posedge clk); #1; chk("fill_edge2_valido", int'(valido), 0);
    @(posedge clk); #1;
    chk("init1_valido", int'(valido), 1);
    chk("init1_binario", int'(binario), 4'b1100);

    // Mid-operation reset, then init latency with 0110 held
    gray_in = 4'b0110; rst_n = 1'b0;
    #1;
    chk("async_rst_binario", int'(binario), 0);
    chk("async_rst_valido", int'(valido), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; chk("lat_edge1_valido", int'(valido), 0);
    @(posedge clk); #1; chk("lat_edge2_valido", int'(valido), 0);
    @(posedge clk); #1;
    chk("lat_edge3_valido", int'(valido), 1);
    chk("lat_edge3_binario", int'(binario), 4'b0100);
    repeat (2) @(posedge clk);
    #1;

    // Walk down to 0, then full sweeps
    step_bin(3, 1'b0); step_bin(2, 1'b0); step_bin(1, 1'b0); step_bin(0, 1'b0);
    @(negedge clk); #1;
    p0 = pasos;
    for (int i = 1; i <= 16; i++) step_bin(i % 16, 1'b1);
    @(negedge clk); #1;
    chk("sweep_up_pasos", pasos - p0, 16);
    p0 = pasos;
    for (int i = 15; i >= 0; i--) step_bin(i, 1'b0);
    @(negedge clk); #1;
    chk("sweep_down_pasos", pasos - p0, 16);

    // Directed wraps
    apply_step(4'b1000, 4'b1111, 1'b0);
    apply_step(4'b0000, 4'b0000, 1'b1);
    apply_step(4'b0001, 4'b0001, 1'b1);

    // Two-bit jump and recovery
    apply_fault(4'b0010, 4'b0001, 1'b1);
    @(posedge clk); #1;
    chk("recov_valido", int'(valido), 1);
    chk("recov_binario", int'(binario), 4'b0011);
    chk("recov_cnt_error", int'(cnt_error), 1);

    // Saturation
    for (int n = 0; n < 150; n++) begin
      apply_fault(4'b0001, 4'b0011, 1'b1);
      apply_fault(4'b0010, 4'b0001, 1'b1);
    end
    @(posedge clk); #1;
    chk("sat_cnt_error", int'(cnt_error), 255);
    chk("sat_binario", int'(binario), 4'b0011);
    chk("sat_valido", int'(valido), 1);

    // en gating
    apply_step(4'b0011, 4'b0010, 1'b0);
    apply_step(4'b0001, 4'b0001, 1'b0);
    apply_step(4'b0000, 4'b0000, 1'b0);
    en = 1'b0;
    apply(4'b0001);
    apply(4'b0011);
    chk("en0_binario", int'(binario), 0);
    chk("en0_valido", int'(valido), 1);
    chk("en0_cnt_error", int'(cnt_error), 255);
    q.push_back('{es_err: 1'b1, bin: 4'b0000, dir: 1'b0, val: 1'b0, cnt: 8'd255});
    en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("en1_recov_binario", int'(binario), 4'b0010);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
